// File: rtl/riscv_inst_assembler.sv
// RV32I instruction assembler: encodes symbolic requests into 32-bit words and
// streams them into IMEM at consecutive word addresses over an acked write port.
module riscv_inst_assembler #(
  parameter int unsigned WORD_LENGTH = 32,
  parameter int unsigned ADDR_WIDTH  = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  base_addr_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [4:0]             req_op_i,
  input  logic [4:0]             req_rd_i,
  input  logic [4:0]             req_rs1_i,
  input  logic [4:0]             req_rs2_i,
  input  logic [WORD_LENGTH-1:0] req_imm_i,
  input  logic                   req_last_i,
  output logic                   imem_we_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  output logic [WORD_LENGTH-1:0] imem_wdata_o,
  input  logic                   imem_ack_i,
  output logic                   err_o,
  output logic [1:0]             err_code_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [ADDR_WIDTH:0]    count_o
);

  localparam int unsigned MSB = WORD_LENGTH - 1;
  localparam int unsigned CW  = ADDR_WIDTH + 1;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_OP    = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_ALIGN = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   last_q, last_d;
  logic                   ready_d, we_d, err_d, busy_d, done_d;
  logic [1:0]             err_code_d;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic [WORD_LENGTH-1:0] wdata_d;
  logic [CW-1:0]          count_d;

  logic [WORD_LENGTH-1:0] enc_word;
  logic [1:0]             enc_err;
  logic [2:0]             f3;
  logic [6:0]             f7;
  logic                   imm12_ok, imm13_ok, imm21_ok, shamt_ok, upper_ok;

  // Signed-range checks: the bits above the field's sign bit must all equal it.
  assign imm12_ok = (&req_imm_i[MSB:11]) | ~(|req_imm_i[MSB:11]);
  assign imm13_ok = (&req_imm_i[MSB:12]) | ~(|req_imm_i[MSB:12]);
  assign imm21_ok = (&req_imm_i[MSB:20]) | ~(|req_imm_i[MSB:20]);
  assign shamt_ok = ~(|req_imm_i[MSB:5]);
  assign upper_ok = ~(|req_imm_i[11:0]);

  // funct3/funct7 lookup shared by every format that carries them.
  always_comb begin
    f3 = 3'd0;
    case (req_op_i)
      5'd0, 5'd1, 5'd10, 5'd22:               f3 = 3'd0;
      5'd2, 5'd16, 5'd23:                     f3 = 3'd1;
      5'd3, 5'd11, 5'd19, 5'd20:              f3 = 3'd2;
      5'd4, 5'd12:                            f3 = 3'd3;
      5'd5, 5'd13, 5'd24:                     f3 = 3'd4;
      5'd6, 5'd7, 5'd17, 5'd18, 5'd25:        f3 = 3'd5;
      5'd8, 5'd14, 5'd26:                     f3 = 3'd6;
      5'd9, 5'd15, 5'd27:                     f3 = 3'd7;
      default:                                f3 = 3'd0;
    endcase
    f7 = (req_op_i == 5'd1 || req_op_i == 5'd7 || req_op_i == 5'd18) ? 7'h20 : 7'h00;
  end

  // Encoder and validator; priority is illegal op, then alignment, then range.
  always_comb begin
    enc_word = '0;
    enc_err  = ERR_NONE;
    if (req_op_i >= 5'd30) begin
      enc_err = ERR_OP;
    end else if (req_op_i <= 5'd9) begin
      enc_word = {f7, req_rs2_i, req_rs1_i, f3, req_rd_i, OPC_OP};
    end else if (req_op_i <= 5'd15 || req_op_i == 5'd19) begin
      if (!imm12_ok) enc_err = ERR_RANGE;
      enc_word = {req_imm_i[11:0], req_rs1_i, f3, req_rd_i,
                  (req_op_i == 5'd19) ? OPC_LOAD : OPC_OPIMM};
    end else if (req_op_i <= 5'd18) begin
      if (!shamt_ok) enc_err = ERR_RANGE;
      enc_word = {f7, req_imm_i[4:0], req_rs1_i, f3, req_rd_i, OPC_OPIMM};
    end else if (req_op_i == 5'd20) begin
      if (!imm12_ok) enc_err = ERR_RANGE;
      enc_word = {req_imm_i[11:5], req_rs2_i, req_rs1_i, f3, req_imm_i[4:0], OPC_STORE};
    end else if (req_op_i == 5'd21) begin
      if (req_imm_i[0])   enc_err = ERR_ALIGN;
      else if (!imm21_ok) enc_err = ERR_RANGE;
      enc_word = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11], req_imm_i[19:12],
                  req_rd_i, OPC_JAL};
    end else if (req_op_i <= 5'd27) begin
      if (req_imm_i[0])   enc_err = ERR_ALIGN;
      else if (!imm13_ok) enc_err = ERR_RANGE;
      enc_word = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i, f3,
                  req_imm_i[4:1], req_imm_i[11], OPC_BRANCH};
    end else begin
      if (!upper_ok) enc_err = ERR_RANGE;
      enc_word = {req_imm_i[31:12], req_rd_i,
                  (req_op_i == 5'd28) ? OPC_LUI : OPC_AUIPC};
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    addr_d     = imem_addr_o;
    wdata_d    = imem_wdata_o;
    count_d    = count_o;
    err_code_d = err_code_o;
    err_d      = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (req_valid_i) begin
          if (enc_err == ERR_NONE) begin
            wdata_d = enc_word;
            last_d  = req_last_i;
            state_d = WRITE;
          end else begin
            err_d      = 1'b1;
            err_code_d = enc_err;
            if (req_last_i) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      WRITE: begin
        if (imem_ack_i) begin
          addr_d = imem_addr_o + ADDR_WIDTH'(1);
          if (!count_o[ADDR_WIDTH]) count_d = count_o + CW'(1);
          if (last_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == RUN);
    we_d    = (state_d == WRITE);
    busy_d  = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= 1'b0;
      req_ready_o  <= 1'b0;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      err_o        <= 1'b0;
      err_code_o   <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      count_o      <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      req_ready_o  <= ready_d;
      imem_we_o    <= we_d;
      imem_addr_o  <= addr_d;
      imem_wdata_o <= wdata_d;
      err_o        <= err_d;
      err_code_o   <= err_code_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
      count_o      <= count_d;
    end
  end

endmodule

// File: tb/tb_riscv_inst_assembler.sv
// Self-checking bench for riscv_inst_assembler: directed scenarios plus random
// requests scored against an arithmetic RV32I encoding model.
module tb_riscv_inst_assembler;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [9:0]  base_addr_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [4:0]  req_op_i, req_rd_i, req_rs1_i, req_rs2_i;
  logic [31:0] req_imm_i;
  logic        req_last_i;
  logic        imem_we_o;
  logic [9:0]  imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        imem_ack_i;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic        busy_o;
  logic        done_o;
  logic [10:0] count_o;

  logic ack_force, ack_rand;
  logic rnd_bit = 1'b0;
  assign imem_ack_i = ack_force | (ack_rand & rnd_bit);

  int errors, checks, done_seen;
  logic [41:0] exp_wr[$];
  logic [1:0]  exp_err[$];
  logic [41:0] mon_wr;
  logic [1:0]  mon_err;
  logic [9:0]  m_addr;
  int          m_count;

  int r_f3 [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  int i_f3 [9]  = '{0, 2, 3, 4, 6, 7, 1, 5, 5};
  int b_f3 [6]  = '{0, 1, 4, 5, 6, 7};

  riscv_inst_assembler dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_rd_i(req_rd_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
    .req_imm_i(req_imm_i), .req_last_i(req_last_i), .imem_we_o(imem_we_o),
    .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o), .imem_ack_i(imem_ack_i),
    .err_o(err_o), .err_code_o(err_code_o), .busy_o(busy_o), .done_o(done_o),
    .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  initial begin
    #500000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Reference encoder: returns {err_code, word}, from the RV32I field layout.
  function automatic logic [33:0] ref_enc(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [31:0] imm);
    int k, s;
    logic [1:0]  c;
    logic [31:0] w, d, a, b;
    k = int'(op);
    s = int'(imm);
    c = 2'd0;
    w = 32'd0;
    d = 32'(rd) << 7;
    a = 32'(rs1) << 15;
    b = 32'(rs2) << 20;
    if (k >= 30) c = 2'd1;
    else if (k <= 9)
      w = ((k == 1 || k == 7) ? 32'h4000_0000 : 32'd0) | b | a | (32'(r_f3[k]) << 12) | d | 32'h33;
    else if (k <= 15 || k == 19) begin
      if (s < -2048 || s > 2047) c = 2'd2;
      w = (imm << 20) | a | (32'(k == 19 ? 2 : i_f3[k-10]) << 12) | d | (k == 19 ? 32'h03 : 32'h13);
    end else if (k <= 18) begin
      if (imm > 32'd31) c = 2'd2;
      w = ((k == 18) ? 32'h4000_0000 : 32'd0) | (imm << 20) | a | (32'(i_f3[k-10]) << 12) | d | 32'h13;
    end else if (k == 20) begin
      if (s < -2048 || s > 2047) c = 2'd2;
      w = ((imm >> 5) << 25) | b | a | (32'd2 << 12) | ((imm & 32'h1F) << 7) | 32'h23;
    end else if (k == 21) begin
      if (s % 2 != 0) c = 2'd3;
      else if (s < -1048576 || s > 1048575) c = 2'd2;
      w = (32'(imm[20]) << 31) | (32'(imm[10:1]) << 21) | (32'(imm[11]) << 20) |
          (32'(imm[19:12]) << 12) | d | 32'h6F;
    end else if (k <= 27) begin
      if (s % 2 != 0) c = 2'd3;
      else if (s < -4096 || s > 4095) c = 2'd2;
      w = (32'(imm[12]) << 31) | (32'(imm[10:5]) << 25) | b | a | (32'(b_f3[k-22]) << 12) |
          (32'(imm[4:1]) << 8) | (32'(imm[11]) << 7) | 32'h63;
    end else begin
      if ((imm & 32'hFFF) != 32'd0) c = 2'd2;
      w = (imm & 32'hFFFF_F000) | d | (k == 28 ? 32'h37 : 32'h17);
    end
    return {c, w};
  endfunction

  // Scoreboard: every acked write and every error pulse is matched in order.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && imem_we_o === 1'b1 && imem_ack_i === 1'b1) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h", imem_addr_o, imem_wdata_o);
      end else begin
        mon_wr = exp_wr.pop_front();
        if ({imem_addr_o, imem_wdata_o} !== mon_wr) begin
          errors++;
          $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                   imem_addr_o, imem_wdata_o, mon_wr[41:32], mon_wr[31:0]);
        end
      end
    end
    if (rst_n === 1'b1 && err_o === 1'b1) begin
      checks++;
      if (exp_err.size() == 0) begin
        errors++;
        $display("FAIL unexpected_err code=%0d", err_code_o);
      end else begin
        mon_err = exp_err.pop_front();
        if (err_code_o !== mon_err) begin
          errors++;
          $display("FAIL err_code got=%0d exp=%0d", err_code_o, mon_err);
        end
      end
    end
    if (done_o === 1'b1) done_seen++;
  end

  task automatic do_start(input logic [9:0] base);
    start_i = 1'b1;
    base_addr_i = base;
    m_addr = base;
    m_count = 0;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic last);
    logic [33:0] r;
    int n;
    n = 0;
    while (req_ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout got=%b exp=1", req_ready_o);
    end
    r = ref_enc(op, rd, rs1, rs2, imm);
    if (r[33:32] == 2'd0) begin
      exp_wr.push_back({m_addr, r[31:0]});
      m_addr = m_addr + 10'd1;
      if (m_count < 1024) m_count++;
    end else begin
      exp_err.push_back(r[33:32]);
    end
    req_valid_i = 1'b1;
    req_op_i = op; req_rd_i = rd; req_rs1_i = rs1; req_rs2_i = rs2;
    req_imm_i = imm; req_last_i = last;
    @(negedge clk);
    req_valid_i = 1'b0;
    req_last_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_timeout busy got=%b exp=0", name, busy_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #13;
    checks++;
    if ({req_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, err_o, err_code_o, busy_o,
         done_o, count_o} !== 60'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", {req_ready_o, imem_we_o, imem_addr_o,
               imem_wdata_o, err_o, err_code_o, busy_o, done_o, count_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle ready/busy got=%b exp=00", {req_ready_o, busy_o});
    end
  endtask

  task automatic test_basic();
    int d0;
    d0 = done_seen;
    ack_force = 1'b1;
    do_start(10'h000);
    send(5'd10, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    checks++;
    if ({imem_we_o, imem_addr_o, imem_wdata_o} !== {1'b1, 10'h000, 32'h0050_0093}) begin
      errors++;
      $display("FAIL addi got we=%b addr=%h data=%h exp 1/000/00500093", imem_we_o, imem_addr_o, imem_wdata_o);
    end
    send(5'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
    checks++;
    if ({imem_addr_o, imem_wdata_o} !== {10'h001, 32'h4020_81B3}) begin
      errors++;
      $display("FAIL sub got addr=%h data=%h exp 001/402081b3", imem_addr_o, imem_wdata_o);
    end
    wait_idle("basic");
    checks++;
    if (done_seen - d0 != 1) begin
      errors++;
      $display("FAIL basic_done got=%0d exp=1", done_seen - d0);
    end
    checks++;
    if (count_o !== 11'd2) begin
      errors++;
      $display("FAIL basic_count got=%0d exp=2", count_o);
    end
    do_start(10'h010);
    send(5'd21, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0);
    checks++;
    if (imem_wdata_o !== 32'h0080_00EF) begin
      errors++;
      $display("FAIL jal got=%h exp=008000ef", imem_wdata_o);
    end
    send(5'd28, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1);
    checks++;
    if (imem_wdata_o !== 32'h1234_52B7) begin
      errors++;
      $display("FAIL lui got=%h exp=123452b7", imem_wdata_o);
    end
    wait_idle("basic2");
  endtask

  task automatic test_errors();
    int d0;
    d0 = done_seen;
    ack_force = 1'b1;
    do_start(10'h020);
    send(5'd10, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
    checks++;
    if ({err_o, err_code_o} !== 3'b1_10) begin
      errors++;
      $display("FAIL err_range got err=%b code=%0d exp 1/2", err_o, err_code_o);
    end
    send(5'd22, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
    checks++;
    if ({err_o, err_code_o} !== 3'b1_11) begin
      errors++;
      $display("FAIL err_align got err=%b code=%0d exp 1/3", err_o, err_code_o);
    end
    send(5'd31, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    @(negedge clk);
    checks++;
    if ({err_o, err_code_o, imem_we_o} !== 4'b0_01_0) begin
      errors++;
      $display("FAIL err_hold got err=%b code=%0d we=%b exp 0/1/0", err_o, err_code_o, imem_we_o);
    end
    checks++;
    if ({imem_addr_o, count_o} !== {10'h020, 11'd0}) begin
      errors++;
      $display("FAIL err_nochange got addr=%h count=%0d exp 020/0", imem_addr_o, count_o);
    end
    send(5'd30, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
    wait_idle("errors");
    checks++;
    if (done_seen - d0 != 1) begin
      errors++;
      $display("FAIL err_last_done got=%0d exp=1", done_seen - d0);
    end
  endtask

  task automatic test_ack_stall();
    ack_force = 1'b0;
    do_start(10'h040);
    send(5'd10, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({imem_we_o, req_ready_o, imem_addr_o, imem_wdata_o} !== {1'b1, 1'b0, 10'h040, 32'hFFF1_0093}) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got we=%b rdy=%b addr=%h data=%h exp 1/0/040/fff10093",
                 i, imem_we_o, req_ready_o, imem_addr_o, imem_wdata_o);
      end
      @(negedge clk);
    end
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    checks++;
    if ({req_ready_o, imem_we_o, imem_addr_o, count_o} !== {1'b1, 1'b0, 10'h041, 11'd1}) begin
      errors++;
      $display("FAIL stall_release got rdy=%b we=%b addr=%h count=%0d exp 1/0/041/1",
               req_ready_o, imem_we_o, imem_addr_o, count_o);
    end
    ack_force = 1'b1;
    send(5'd29, 5'd7, 5'd0, 5'd0, 32'hABCD_E000, 1'b1);
    wait_idle("stall");
    checks++;
    if (exp_wr.size() != 0) begin
      errors++;
      $display("FAIL stall_pending got=%0d exp=0", exp_wr.size());
    end
  endtask

  task automatic test_wrap();
    ack_force = 1'b1;
    do_start(10'h3FF);
    send(5'd0, 5'd4, 5'd5, 5'd6, 32'd0, 1'b0);
    checks++;
    if (imem_addr_o !== 10'h3FF) begin
      errors++;
      $display("FAIL wrap_first got=%h exp=3ff", imem_addr_o);
    end
    send(5'd5, 5'd7, 5'd8, 5'd9, 32'd0, 1'b1);
    checks++;
    if (imem_addr_o !== 10'h000) begin
      errors++;
      $display("FAIL wrap_second got=%h exp=000", imem_addr_o);
    end
    wait_idle("wrap");
    checks++;
    if (count_o !== 11'd2) begin
      errors++;
      $display("FAIL wrap_count got=%0d exp=2", count_o);
    end
  endtask

  task automatic test_random();
    int d0;
    logic [31:0] imm;
    d0 = done_seen;
    ack_force = 1'b0;
    ack_rand = 1'b1;
    do_start(10'($urandom));
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 8000)) - 32'd4000;
        2: imm = $urandom & 32'hFFFF_F000;
        default: imm = 32'($urandom_range(0, 40));
      endcase
      send(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm, i == 59);
    end
    wait_idle("random");
    ack_rand = 1'b0;
    checks++;
    if (exp_wr.size() != 0 || exp_err.size() != 0) begin
      errors++;
      $display("FAIL random_pending got wr=%0d err=%0d exp 0/0", exp_wr.size(), exp_err.size());
    end
    checks++;
    if (int'(count_o) != m_count) begin
      errors++;
      $display("FAIL random_count got=%0d exp=%0d", count_o, m_count);
    end
    checks++;
    if (done_seen - d0 != 1) begin
      errors++;
      $display("FAIL random_done got=%0d exp=1", done_seen - d0);
    end
  endtask

  task automatic test_saturate();
    ack_force = 1'b1;
    do_start(10'h000);
    for (int i = 0; i < 1030; i++)
      send(5'd10, 5'(i), 5'(i >> 5), 5'd0, 32'(i & 255), i == 1029);
    wait_idle("saturate");
    checks++;
    if (count_o !== 11'd1024) begin
      errors++;
      $display("FAIL sat_count got=%0d exp=1024", count_o);
    end
    checks++;
    if (imem_addr_o !== 10'd6 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL sat_addr got addr=%0d pending=%0d exp 6/0", imem_addr_o, exp_wr.size());
    end
  endtask

  task automatic test_reset_mid_write();
    ack_force = 1'b0;
    do_start(10'h100);
    send(5'd10, 5'd1, 5'd1, 5'd0, 32'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, err_o, err_code_o, busy_o,
         done_o, count_o} !== 60'd0) begin
      errors++;
      $display("FAIL midrst_outputs got=%h exp=0", {req_ready_o, imem_we_o, imem_addr_o,
               imem_wdata_o, err_o, err_code_o, busy_o, done_o, count_o});
    end
    exp_wr.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ack_force = 1'b1;
    req_valid_i = 1'b1;
    req_op_i = 5'd10;
    req_imm_i = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({req_ready_o, busy_o, imem_we_o} !== 3'b000) begin
        errors++;
        $display("FAIL midrst_nostart cyc=%0d got rdy/busy/we=%b exp=000", i,
                 {req_ready_o, busy_o, imem_we_o});
      end
    end
    req_valid_i = 1'b0;
    do_start(10'h200);
    send(5'd20, 5'd0, 5'd3, 5'd4, 32'hFFFF_FFF8, 1'b1);
    wait_idle("midrst");
    checks++;
    if (imem_addr_o !== 10'h201 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL midrst_restart got addr=%h pending=%0d exp 201/0", imem_addr_o, exp_wr.size());
    end
  endtask

  initial begin
    errors = 0; checks = 0; done_seen = 0;
    m_addr = '0; m_count = 0;
    rst_n = 1'b0; start_i = 1'b0; base_addr_i = '0;
    req_valid_i = 1'b0; req_op_i = '0; req_rd_i = '0; req_rs1_i = '0; req_rs2_i = '0;
    req_imm_i = '0; req_last_i = 1'b0;
    ack_force = 1'b0; ack_rand = 1'b0;
    test_reset();
    test_basic();
    test_errors();
    test_ack_stall();
    test_wrap();
    test_random();
    test_saturate();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_inst_assembler.md
# riscv_inst_assembler

Sequential RV32I instruction assembler. It accepts symbolic instruction requests (operation, register indices, immediate) over a valid/ready handshake and encodes each one into a standard 32-bit RV32I word. It writes the words into instruction memory at consecutive word addresses through a write port with acknowledge. It is the producer-side counterpart of the core's instruction decoder, used by the boot/program loader and by the core testbenches to build programs in IMEM.

## Interface
- WORD_LENGTH, 32, instruction and immediate width.
- ADDR_WIDTH, 10, IMEM word-address width.

- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  pulse; honoured only in IDLE.
- base_addr_i  in  ADDR_WIDTH  first write address, sampled with start_i.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_op_i  in  5  operation code:
  - 0-9: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - 10-18: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - 19 LW, 20 SW, 21 JAL.
  - 22-27: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - 28 LUI, 29 AUIPC.
  - 30-31 illegal.
- req_rd_i, req_rs1_i, req_rs2_i  in  5 each  register indices. A field is ignored when the format has no such field.
- req_imm_i  in  WORD_LENGTH  signed byte-offset/immediate. For U-type it is the full 32-bit value.
- req_last_i  in  1  marks the final request of the program.
- imem_we_o  out  1  write strobe.
- imem_addr_o  out  ADDR_WIDTH  write word address.
- imem_wdata_o  out  WORD_LENGTH  encoded instruction.
- imem_ack_i  in  1  memory accepted the write this cycle.
- err_o  out  1  one-cycle pulse: the request was rejected.
- err_code_o  out  2  1 illegal op, 2 immediate out of range, 3 misaligned branch/jump offset. Holds until the next error.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse when the last request completes.
- count_o  out  ADDR_WIDTH+1  words written since start; saturates at 2^ADDR_WIDTH.

## Operation
- States: IDLE, RUN, WRITE.
- IDLE, on start_i: addr <= base_addr_i, count <= 0, next state RUN. start_i in RUN or WRITE is ignored.
- RUN: req_ready_o=1. On req_valid_i, the request is validated and encoded combinationally and registered.
  - If valid: the word goes to the wdata register, last is latched, next state WRITE.
  - If invalid: nothing is written, err_o pulses the next cycle, and err_code_o is updated. Next state is RUN, or IDLE with a done_o pulse if req_last_i=1.
- WRITE: imem_we_o=1 while req_ready_o=0. Address and data are held stable until imem_ack_i.
  - On ack: addr <= addr+1, wrapping modulo 2^ADDR_WIDTH; count increments (saturating).
  - If last: done_o pulses the next cycle and the next state is IDLE. Otherwise the next state is RUN.
- Encoding follows standard RV32I opcodes and funct3/funct7:
  - SUB and SRA/SRAI use funct7 0x20.
  - LW and SW use funct3 010.
- Immediate checks, in priority order: illegal op, then misaligned, then range.
  - R-type: immediate ignored.
  - I-type arithmetic, LW, SW: req_imm_i[31:11] must all be equal (12-bit signed).
  - SLLI/SRLI/SRAI: req_imm_i[31:5] must be 0.
  - B-type: bit0 must be 0; 13-bit signed.
  - JAL: bit0 must be 0; 21-bit signed.
  - LUI/AUIPC: req_imm_i[11:0] must be 0; the encoding uses bits 31:12.
- Register indices are never range-checked; they are 5 bits wide.

## Timing
- Reset values, asynchronous: state IDLE, addr 0, count 0, wdata 0. All outputs are 0, including req_ready_o, imem_we_o, err_o, err_code_o and done_o.
- Latency: request accepted in cycle N; imem_we_o is asserted in cycle N+1. With imem_ack_i tied high, the peak rate is one instruction per 2 cycles.
- imem_we_o, imem_addr_o and imem_wdata_o are registered outputs and do not change while waiting for ack.
- imem_ack_i while imem_we_o=0 is ignored.
- Reset asserted mid-WRITE drops imem_we_o immediately. No partial state survives.
- Address wrap at 2^ADDR_WIDTH-1 is silent. count_o continues until it saturates.

## Test plan
- start base 0x000; ADDI rd=1 rs1=0 imm=5, then SUB rd=3 rs1=1 rs2=2 (last), ack tied high -> writes 0x00500093 @0x000 and 0x402081B3 @0x001; done_o pulses once; count_o=2.
- JAL rd=1 imm=8 -> 0x008000EF. LUI rd=5 imm=0x12345000 -> 0x123452B7.
- ADDI imm=2048 -> err_o with code 2, no write. BEQ imm=3 -> code 3. op=31 -> code 1. addr and count are unchanged after all three.
- Hold imem_ack_i low 3 cycles during WRITE -> we, addr and data stay stable and req_ready_o=0; the 4th cycle acks and the block returns to RUN.
- base 0x3FF, two valid requests -> writes at 0x3FF then 0x000.
- Assert rst_n low mid-WRITE -> all outputs 0 asynchronously. After release the block is in IDLE, and start_i is required before any request is accepted.
